// File: rtl/spi_regbus_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge.
//   state_e   : bridge FSM states
//   CMD_BITS  : command byte length (R/nW + address)
//   DATA_BITS : data word length
//   ADDR_W    : register address width carried in the command byte
package spi_regbus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int unsigned CMD_BITS  = 8;
   localparam int unsigned DATA_BITS = 32;
   localparam int unsigned ADDR_W    = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus a third flop for
// edge detection.
//   clk   : sampling clock
//   reset : synchronous active-high reset (chain clears to 0)
//   d     : asynchronous input
//   level : synchronized level
//   rise  : one-clk pulse on a synchronized 0->1 transition
//   fall  : one-clk pulse on a synchronized 1->0 transition
module spi_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [2:0] sh_q;
   logic [2:0] sh_d;

   always_comb begin
      sh_d = {sh_q[1:0], d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q <= 3'b000;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign level = sh_q[1];
   assign rise  = sh_q[1] & ~sh_q[2];
   assign fall  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_regbus_slave.sv
// SPI mode-0 slave that bridges host frames onto the internal register bus.
// Frame: command byte (bit7 = R/nW, bits 6:0 = address) then a 32-bit word,
// both MSB first. All SPI inputs are oversampled in the clk domain.
//   clk, reset      : system clock, synchronous active-high reset
//   spiclk/spimosi  : SPI SCLK and MOSI (asynchronous)
//   spicsl          : SPI chip select, active low (asynchronous)
//   spimiso         : SPI data out, 0 outside the read data phase
//   we / re         : one-clk write / read strobes
//   addr, wdat      : register address and write data, held between frames
//   rdat            : combinational readback for the current addr
// Build option: define SPI_REGBUS_BURST_EN to keep transferring words while
// CS stays low, with addr incrementing (wrapping) after each word.
module spi_regbus_slave #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spiclk,
   input  logic              spimosi,
   input  logic              spicsl,
   output logic              spimiso,
   output logic              we,
   output logic              re,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdat,
   input  logic [DATA_W-1:0] rdat
);

   import spi_regbus_pkg::*;

   localparam logic [5:0] CmdLast  = 6'(CMD_BITS - 1);
   localparam logic [5:0] DataLast = 6'(DATA_BITS - 1);

   logic sclk_level, sclk_rise, sclk_fall;
   logic mosi_level, mosi_rise, mosi_fall;
   logic csl_level, csl_rise, csl_fall;

   spi_sync_edge u_sync_sclk (
      .clk   (clk),
      .reset (reset),
      .d     (spiclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge u_sync_mosi (
      .clk   (clk),
      .reset (reset),
      .d     (spimosi),
      .level (mosi_level),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   spi_sync_edge u_sync_csl (
      .clk   (clk),
      .reset (reset),
      .d     (spicsl),
      .level (csl_level),
      .rise  (csl_rise),
      .fall  (csl_fall)
   );

   logic unused_sync;
   assign unused_sync = sclk_level ^ mosi_rise ^ mosi_fall;

   // SCLK edges only count while CS is low.
   logic rise_g, fall_g;
   assign rise_g = sclk_rise & ~csl_level;
   assign fall_g = sclk_fall & ~csl_level;

   state_e            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              rd_q, rd_d;
   // Address of the word currently being written; addr only follows it when
   // a write word completes, so aborted writes leave addr untouched.
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;
   logic              we_q, we_d;
   logic              re_q, re_d;

   logic [ADDR_W-1:0] cmd_addr;
   assign cmd_addr = ADDR_W'({rx_q[5:0], mosi_level});

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      rd_d    = rd_q;
      wa_d    = wa_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      we_d    = 1'b0;
      re_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (csl_fall) begin
               state_d = CMD;
               cnt_d   = 6'd0;
               tx_d    = '0;
            end
         end
         CMD: begin
            if (rise_g) begin
               rx_d  = {rx_q[DATA_W-2:0], mosi_level};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == CmdLast) begin
                  state_d = DATA;
                  cnt_d   = 6'd0;
                  rd_d    = rx_q[6];
                  wa_d    = cmd_addr;
                  if (rx_q[6]) begin
                     addr_d = cmd_addr;
                     re_d   = 1'b1;
                  end
               end
            end
         end
         DATA: begin
            if (rd_q) begin
               // cnt counts host sample rises; the fall that closes the
               // command byte (cnt==0) must not disturb the freshly loaded bit.
               if (fall_g && (cnt_q != 6'd0)) begin
                  tx_d = {tx_q[DATA_W-2:0], 1'b0};
               end
               if (rise_g) begin
                  cnt_d = cnt_q + 6'd1;
                  if (cnt_q == DataLast) begin
`ifdef SPI_REGBUS_BURST_EN
                     cnt_d  = 6'd0;
                     addr_d = addr_q + ADDR_W'(1);
                     re_d   = 1'b1;
`else
                     state_d = DONE;
`endif
                  end
               end
            end else if (rise_g) begin
               rx_d  = {rx_q[DATA_W-2:0], mosi_level};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == DataLast) begin
                  wdat_d = {rx_q[DATA_W-2:0], mosi_level};
                  addr_d = wa_q;
                  we_d   = 1'b1;
`ifdef SPI_REGBUS_BURST_EN
                  cnt_d = 6'd0;
                  wa_d  = wa_q + ADDR_W'(1);
`else
                  state_d = DONE;
`endif
               end
            end
         end
         DONE: begin
         end
         default: state_d = IDLE;
      endcase

      // Readback is sampled the cycle after the read strobe.
      if (re_q) begin
         tx_d = rdat;
      end

      if (csl_rise) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         rx_q    <= '0;
         tx_q    <= '0;
         rd_q    <= 1'b0;
         wa_q    <= '0;
         addr_q  <= '0;
         wdat_q  <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
         wa_q    <= wa_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         we_q    <= we_d;
         re_q    <= re_d;
      end
   end

   assign spimiso = ((state_q == DATA) && rd_q) ? tx_q[DATA_W-1] : 1'b0;
   assign we      = we_q;
   assign re      = re_q;
   assign addr    = addr_q;
   assign wdat    = wdat_q;

endmodule

// File: tb/tb_spi_regbus_slave.sv
module tb_spi_regbus_slave;

   logic        clk;
   logic        reset;
   logic        spiclk;
   logic        spimosi;
   logic        spicsl;
   logic        spimiso;
   logic        we;
   logic        re;
   logic [6:0]  addr;
   logic [31:0] wdat;
   logic [31:0] rdat;

   int tests_run;
   int tests_failed;

   int          we_cnt;
   int          re_cnt;
   int          both_cnt;
   int          consec_cnt;
   logic        prev_strobe;
   logic [6:0]  we_addr_log [4];
   logic [31:0] we_dat_log  [4];
   logic [6:0]  re_addr_log [4];

   spi_regbus_slave #(
      .ADDR_W (7),
      .DATA_W (32)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .spiclk  (spiclk),
      .spimosi (spimosi),
      .spicsl  (spicsl),
      .spimiso (spimiso),
      .we      (we),
      .re      (re),
      .addr    (addr),
      .wdat    (wdat),
      .rdat    (rdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench register file readback mux.
   always_comb begin
      case (addr)
         7'h00:   rdat = 32'hB00C_0000;
         7'h05:   rdat = 32'h5A5A_0005;
         default: rdat = 32'hC0DE_0000 | {25'h0, addr};
      endcase
   end

   // Strobe monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (we) begin
         if (we_cnt < 4) begin
            we_addr_log[we_cnt] = addr;
            we_dat_log[we_cnt]  = wdat;
         end
         we_cnt = we_cnt + 1;
      end
      if (re) begin
         if (re_cnt < 4) re_addr_log[re_cnt] = addr;
         re_cnt = re_cnt + 1;
      end
      if (we && re) both_cnt = both_cnt + 1;
      if ((we || re) && prev_strobe) consec_cnt = consec_cnt + 1;
      prev_strobe = we || re;
   end

   task automatic clear_log();
      we_cnt = 0;
      re_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         we_addr_log[i] = 7'h7E;
         we_dat_log[i]  = 32'hFFFF_FFFF;
         re_addr_log[i] = 7'h7E;
      end
   endtask

   task automatic cs_low();
      spicsl = 1'b0;
      #40;
   endtask

   task automatic cs_high();
      #40;
      spicsl = 1'b1;
      #60;
   endtask

   // Shift n bits of val MSB first at SCLK = clk/8; MISO sampled at each rise.
   task automatic send_bits(input logic [31:0] val, input int n, output logic [31:0] got);
      got = 32'h0;
      for (int i = n - 1; i >= 0; i--) begin
         spimosi = val[i];
         #40;
         got    = {got[30:0], spimiso};
         spiclk = 1'b1;
         #40;
         spiclk = 1'b0;
      end
   endtask

   task automatic write_frame(input logic [6:0] a, input logic [31:0] d,
                              output logic [31:0] miso_seen);
      logic [31:0] g;
      cs_low();
      send_bits({24'h0, 1'b0, a}, 8, g);
      send_bits(d, 32, miso_seen);
      cs_high();
   endtask

   task automatic read_frame(input logic [6:0] a, output logic [31:0] word);
      logic [31:0] g;
      cs_low();
      send_bits({24'h0, 1'b1, a}, 8, g);
      send_bits(32'h0, 32, word);
      cs_high();
   endtask

   task automatic test_reset();
      tests_run++;
      if (we !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_we: got %b expected 0", we);
      end
      tests_run++;
      if (re !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_re: got %b expected 0", re);
      end
      tests_run++;
      if (addr !== 7'h00) begin
         tests_failed++;
         $display("FAIL reset_addr: got %h expected 00", addr);
      end
      tests_run++;
      if (wdat !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_wdat: got %h expected 0", wdat);
      end
      tests_run++;
      if (spimiso !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_miso: got %b expected 0", spimiso);
      end
   endtask

   task automatic test_write();
      logic [31:0] m;
      clear_log();
      write_frame(7'h01, 32'h0000_1234, m);
      tests_run++;
      if (we_cnt != 1) begin
         tests_failed++;
         $display("FAIL write_we_count: got %0d expected 1", we_cnt);
      end
      tests_run++;
      if (we_addr_log[0] !== 7'h01) begin
         tests_failed++;
         $display("FAIL write_addr: got %h expected 01", we_addr_log[0]);
      end
      tests_run++;
      if (we_dat_log[0] !== 32'h0000_1234) begin
         tests_failed++;
         $display("FAIL write_data: got %h expected 00001234", we_dat_log[0]);
      end
      tests_run++;
      if (re_cnt != 0) begin
         tests_failed++;
         $display("FAIL write_no_re: got %0d expected 0", re_cnt);
      end
      tests_run++;
      if (m !== 32'h0) begin
         tests_failed++;
         $display("FAIL write_miso_quiet: got %h expected 0", m);
      end
   endtask

   task automatic test_read();
      logic [31:0] w;
      clear_log();
      read_frame(7'h00, w);
      tests_run++;
      if (re_cnt != 1) begin
         tests_failed++;
         $display("FAIL read_re_count: got %0d expected 1", re_cnt);
      end
      tests_run++;
      if (re_addr_log[0] !== 7'h00) begin
         tests_failed++;
         $display("FAIL read_addr: got %h expected 00", re_addr_log[0]);
      end
      tests_run++;
      if (w !== 32'hB00C_0000) begin
         tests_failed++;
         $display("FAIL read_data: got %h expected b00c0000", w);
      end
      tests_run++;
      if (we_cnt != 0) begin
         tests_failed++;
         $display("FAIL read_no_we: got %0d expected 0", we_cnt);
      end
      tests_run++;
      if (spimiso !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_miso_idle: got %b expected 0", spimiso);
      end
   endtask

   task automatic test_abort();
      logic [31:0] g;
      clear_log();
      cs_low();
      send_bits(32'h0000_0003, 8, g);
      send_bits(32'h000A_BCDE, 20, g);
      cs_high();
      tests_run++;
      if (we_cnt != 0) begin
         tests_failed++;
         $display("FAIL abort_no_we: got %0d expected 0", we_cnt);
      end
      tests_run++;
      if (addr !== 7'h00) begin
         tests_failed++;
         $display("FAIL abort_addr_held: got %h expected 00", addr);
      end
      tests_run++;
      if (wdat !== 32'h0000_1234) begin
         tests_failed++;
         $display("FAIL abort_wdat_held: got %h expected 00001234", wdat);
      end
      write_frame(7'h03, 32'hDEAD_BEEF, g);
      tests_run++;
      if (we_cnt != 1) begin
         tests_failed++;
         $display("FAIL abort_next_we_count: got %0d expected 1", we_cnt);
      end
      tests_run++;
      if (we_addr_log[0] !== 7'h03) begin
         tests_failed++;
         $display("FAIL abort_next_addr: got %h expected 03", we_addr_log[0]);
      end
      tests_run++;
      if (we_dat_log[0] !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL abort_next_data: got %h expected deadbeef", we_dat_log[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] g;
      clear_log();
      cs_low();
      send_bits(32'h0000_0004, 8, g);
      send_bits(32'h0000_8765, 16, g);
      reset = 1'b1;
      #30;
      reset = 1'b0;
      #20;
      send_bits(32'h0000_4321, 16, g);
      cs_high();
      tests_run++;
      if (we_cnt != 0) begin
         tests_failed++;
         $display("FAIL rstmid_no_we: got %0d expected 0", we_cnt);
      end
      tests_run++;
      if (addr !== 7'h00) begin
         tests_failed++;
         $display("FAIL rstmid_addr: got %h expected 00", addr);
      end
      tests_run++;
      if (wdat !== 32'h0) begin
         tests_failed++;
         $display("FAIL rstmid_wdat: got %h expected 0", wdat);
      end
      write_frame(7'h04, 32'h600D_F00D, g);
      tests_run++;
      if (we_cnt != 1) begin
         tests_failed++;
         $display("FAIL rstmid_next_we_count: got %0d expected 1", we_cnt);
      end
      tests_run++;
      if (we_addr_log[0] !== 7'h04) begin
         tests_failed++;
         $display("FAIL rstmid_next_addr: got %h expected 04", we_addr_log[0]);
      end
      tests_run++;
      if (we_dat_log[0] !== 32'h600D_F00D) begin
         tests_failed++;
         $display("FAIL rstmid_next_data: got %h expected 600df00d", we_dat_log[0]);
      end
   endtask

   task automatic test_burst();
      logic [31:0] g;
      clear_log();
      cs_low();
      send_bits(32'h0000_007F, 8, g);
      send_bits(32'h0000_000A, 32, g);
      send_bits(32'h0000_000B, 32, g);
      cs_high();
`ifdef SPI_REGBUS_BURST_EN
      tests_run++;
      if (we_cnt != 2) begin
         tests_failed++;
         $display("FAIL burst_we_count: got %0d expected 2", we_cnt);
      end
      tests_run++;
      if (we_addr_log[0] !== 7'h7F || we_dat_log[0] !== 32'hA) begin
         tests_failed++;
         $display("FAIL burst_word0: got %h/%h expected 7f/0000000a",
                  we_addr_log[0], we_dat_log[0]);
      end
      tests_run++;
      if (we_addr_log[1] !== 7'h00 || we_dat_log[1] !== 32'hB) begin
         tests_failed++;
         $display("FAIL burst_word1: got %h/%h expected 00/0000000b",
                  we_addr_log[1], we_dat_log[1]);
      end
`else
      tests_run++;
      if (we_cnt != 1) begin
         tests_failed++;
         $display("FAIL single_we_count: got %0d expected 1", we_cnt);
      end
      tests_run++;
      if (we_addr_log[0] !== 7'h7F || we_dat_log[0] !== 32'hA) begin
         tests_failed++;
         $display("FAIL single_word: got %h/%h expected 7f/0000000a",
                  we_addr_log[0], we_dat_log[0]);
      end
`endif
   endtask

   task automatic stray_sclk(input int n);
      for (int i = 0; i < n; i++) begin
         spimosi = i[0];
         #40;
         spiclk = 1'b1;
         #40;
         spiclk = 1'b0;
      end
      #40;
   endtask

   task automatic test_stray();
      logic [31:0] w;
      clear_log();
      spicsl = 1'b1;
      stray_sclk(12);
      tests_run++;
      if (we_cnt != 0 || re_cnt != 0) begin
         tests_failed++;
         $display("FAIL stray_pre: got we=%0d re=%0d expected 0/0", we_cnt, re_cnt);
      end
      read_frame(7'h05, w);
      stray_sclk(10);
      tests_run++;
      if (re_cnt != 1) begin
         tests_failed++;
         $display("FAIL stray_re_count: got %0d expected 1", re_cnt);
      end
      tests_run++;
      if (re_addr_log[0] !== 7'h05) begin
         tests_failed++;
         $display("FAIL stray_re_addr: got %h expected 05", re_addr_log[0]);
      end
      tests_run++;
      if (w !== 32'h5A5A_0005) begin
         tests_failed++;
         $display("FAIL stray_read_data: got %h expected 5a5a0005", w);
      end
      tests_run++;
      if (we_cnt != 0) begin
         tests_failed++;
         $display("FAIL stray_no_we: got %0d expected 0", we_cnt);
      end
   endtask

   task automatic test_strobe_rules();
      tests_run++;
      if (both_cnt != 0) begin
         tests_failed++;
         $display("FAIL strobe_overlap: got %0d expected 0", both_cnt);
      end
      tests_run++;
      if (consec_cnt != 0) begin
         tests_failed++;
         $display("FAIL strobe_consecutive: got %0d expected 0", consec_cnt);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      both_cnt     = 0;
      consec_cnt   = 0;
      prev_strobe  = 1'b0;
      clear_log();
      reset   = 1'b1;
      spiclk  = 1'b0;
      spimosi = 1'b0;
      spicsl  = 1'b1;
      #60;
      test_reset();
      #40;
      reset = 1'b0;
      #60;
      test_write();
      test_read();
      test_abort();
      test_reset_mid();
      test_burst();
      test_stray();
      test_strobe_rules();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
